// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-step controller for an EHXPLLL-style PLL: qualifies lock, gates the
// downstream reset, and sequences phasestep pulses while tracking per-output positions.
module pll_phase_ctrl #(
   parameter int NUM_OUT            = 3,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int SETUP_CYCLES       = 2,
   parameter int STEP_LOW           = 4,
   parameter int STEP_HIGH          = 4,
   parameter int POS_W              = 8
) (
   input  logic                     clkin,
   input  logic                     resetn,
   input  logic                     pll_locked,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_chan,
   input  logic                     req_dir,
   input  logic [7:0]               req_steps,
   output logic [1:0]               phasesel,
   output logic                     phasedir,
   output logic                     phasestep,
   output logic                     phaseloadreg,
   output logic                     sys_rst_n,
   output logic                     done,
   output logic                     err,
   output logic [NUM_OUT*POS_W-1:0] phase_pos,
   output logic [7:0]               relock_cnt
);

   localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int TMAX_A = (SETUP_CYCLES > STEP_LOW) ? SETUP_CYCLES : STEP_LOW;
   localparam int TMAX   = (TMAX_A > STEP_HIGH) ? TMAX_A : STEP_HIGH;
   localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(SETUP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LO_LAST    = TMR_W'(STEP_LOW - 1);
   localparam logic [TMR_W-1:0]  HI_LAST    = TMR_W'(STEP_HIGH - 1);
   localparam logic [2:0]        NUM_OUT_L  = 3'(NUM_OUT);

   typedef enum logic [2:0] {
      S_LOCK_WAIT,
      S_STABLE,
      S_IDLE,
      S_SETUP,
      S_PULSE_LO,
      S_PULSE_HI
   } state_t;

   state_t                     state_q, state_d;
   logic                       sync1_q, sync2_q;
   logic [STAB_W-1:0]          stab_q, stab_d;
   logic [TMR_W-1:0]           tmr_q, tmr_d;
   logic [7:0]                 steps_q, steps_d;
   logic [1:0]                 sel_q, sel_d;
   logic                       dir_q, dir_d;
   logic [NUM_OUT*POS_W-1:0]   pos_q, pos_d;
   logic [7:0]                 relock_q, relock_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic                       rstn_q, rstn_d;
   logic                       ready_q, ready_d;
   logic                       step_q, step_d;
   logic                       step_adv;
   logic                       lock_s;

   assign lock_s = sync2_q;

   always_comb begin
      state_d  = state_q;
      stab_d   = stab_q;
      tmr_d    = tmr_q;
      steps_d  = steps_q;
      sel_d    = sel_q;
      dir_d    = dir_q;
      pos_d    = pos_q;
      relock_d = relock_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      step_adv = 1'b0;

      case (state_q)
         S_LOCK_WAIT: begin
            stab_d = '0;
            if (lock_s) state_d = S_STABLE;
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_d = S_LOCK_WAIT;
               stab_d  = '0;
            end else if (stab_q == STAB_LAST) begin
               state_d = S_IDLE;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (req_valid && ready_q) begin
               if ({1'b0, req_chan} >= NUM_OUT_L) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else if (req_steps == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  sel_d   = req_chan;
                  dir_d   = req_dir;
                  steps_d = req_steps;
                  tmr_d   = '0;
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            if (tmr_q == SETUP_LAST) begin
               tmr_d   = '0;
               state_d = S_PULSE_LO;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_PULSE_LO: begin
            if (tmr_q == LO_LAST) begin
               tmr_d    = '0;
               state_d  = S_PULSE_HI;
               step_adv = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_PULSE_HI: begin
            if (tmr_q == HI_LAST) begin
               tmr_d = '0;
               if (steps_q == 8'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  steps_d = steps_q - 1'b1;
                  state_d = S_PULSE_LO;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = S_LOCK_WAIT;
      endcase

      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         if (step_adv && (sel_q == 2'(k))) begin
            if (dir_q)
               pos_d[k*POS_W +: POS_W] = pos_q[k*POS_W +: POS_W] - POS_W'(1);
            else
               pos_d[k*POS_W +: POS_W] = pos_q[k*POS_W +: POS_W] + POS_W'(1);
         end
      end

      // Lock loss while operational overrides everything decided above.
      if (!lock_s && (state_q inside {S_IDLE, S_SETUP, S_PULSE_LO, S_PULSE_HI})) begin
         state_d = S_LOCK_WAIT;
         done_d  = 1'b0;
         err_d   = 1'b0;
         pos_d   = '0;
         tmr_d   = '0;
         stab_d  = '0;
         if (relock_q != 8'hFF) relock_d = relock_q + 1'b1;
      end

      rstn_d  = state_d inside {S_IDLE, S_SETUP, S_PULSE_LO, S_PULSE_HI};
      ready_d = (state_d == S_IDLE);
      step_d  = (state_d != S_PULSE_LO);
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_LOCK_WAIT;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stab_q   <= '0;
         tmr_q    <= '0;
         steps_q  <= '0;
         sel_q    <= '0;
         dir_q    <= 1'b0;
         pos_q    <= '0;
         relock_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rstn_q   <= 1'b0;
         ready_q  <= 1'b0;
         step_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         sync1_q  <= pll_locked;
         sync2_q  <= sync1_q;
         stab_q   <= stab_d;
         tmr_q    <= tmr_d;
         steps_q  <= steps_d;
         sel_q    <= sel_d;
         dir_q    <= dir_d;
         pos_q    <= pos_d;
         relock_q <= relock_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rstn_q   <= rstn_d;
         ready_q  <= ready_d;
         step_q   <= step_d;
      end
   end

   assign req_ready    = ready_q;
   assign phasesel     = sel_q;
   assign phasedir     = dir_q;
   assign phasestep    = step_q;
   assign phaseloadreg = 1'b1;
   assign sys_rst_n    = rstn_q;
   assign done         = done_q;
   assign err          = err_q;
   assign phase_pos    = pos_q;
   assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboarded bench for pll_phase_ctrl: directed requests push expected completions,
// a monitor checks each done pulse, pulse widths and phasesel/phasedir.
module tb_pll_phase_ctrl;

   logic        clk = 1'b0;
   logic        resetn, pll_locked, req_valid, req_dir;
   logic [1:0]  req_chan;
   logic [7:0]  req_steps;
   logic        req_ready, phasedir, phasestep, phaseloadreg, sys_rst_n, done, err;
   logic [1:0]  phasesel;
   logic [23:0] phase_pos;
   logic [7:0]  relock_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int          exp_cyc;
      logic        exp_err;
      int          exp_pulses;
      logic [1:0]  exp_sel;
      logic        exp_dir;
      logic [23:0] exp_pos;
   } exp_t;

   exp_t sb[$];

   pll_phase_ctrl #(
      .NUM_OUT(3),
      .LOCK_STABLE_CYCLES(16),
      .SETUP_CYCLES(2),
      .STEP_LOW(4),
      .STEP_HIGH(4),
      .POS_W(8)
   ) dut (
      .clkin(clk),
      .resetn(resetn),
      .pll_locked(pll_locked),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_chan(req_chan),
      .req_dir(req_dir),
      .req_steps(req_steps),
      .phasesel(phasesel),
      .phasedir(phasedir),
      .phasestep(phasestep),
      .phaseloadreg(phaseloadreg),
      .sys_rst_n(sys_rst_n),
      .done(done),
      .err(err),
      .phase_pos(phase_pos),
      .relock_cnt(relock_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pulse shape, select/dir during pulses, and completion scoreboard.
   int lowcnt = 0;
   int pulses = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!resetn || !sys_rst_n) begin
         lowcnt = 0;
         pulses = 0;
      end else if (!phasestep) begin
         if (lowcnt == 0 && sb.size() > 0) begin
            check("pulse_phasesel", 32'(phasesel), 32'(sb[0].exp_sel));
            check("pulse_phasedir", 32'(phasedir), 32'(sb[0].exp_dir));
         end
         lowcnt++;
      end else if (lowcnt != 0) begin
         check("pulse_width", lowcnt, 4);
         pulses++;
         lowcnt = 0;
      end
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 0);
         end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.exp_cyc);
            check("done_err", 32'(err), 32'(e.exp_err));
            check("done_pulses", pulses, e.exp_pulses);
            check("done_phase_pos", 32'(phase_pos), 32'(e.exp_pos));
         end
         pulses = 0;
      end else if (err) begin
         check("err_without_done", 32'(err), 0);
      end
   end

   task automatic send(input logic [1:0] ch, input logic d, input logic [7:0] st,
                       input bit track, input logic e_err, input int lat,
                       input int npul, input logic [23:0] pos);
      int   w = 0;
      exp_t e;
      @(negedge clk);
      while (!req_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", 32'(req_ready), 1);
      if (!req_ready) return;
      if (track) begin
         e.exp_cyc    = cyc + 1 + lat;
         e.exp_err    = e_err;
         e.exp_pulses = npul;
         e.exp_sel    = ch;
         e.exp_dir    = d;
         e.exp_pos    = pos;
         sb.push_back(e);
      end
      req_valid = 1'b1;
      req_chan  = ch;
      req_dir   = d;
      req_steps = st;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (sb.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("done_timeout", sb.size(), 0);
   endtask

   task automatic measure_rise(input string name);
      int n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (sys_rst_n) break;
      end
      check(name, n, 19);
      check({name, "_ready"}, 32'(req_ready), 1);
   endtask

   initial begin
      int   n;
      int   falls;
      logic prev;
      logic seen_high;

      resetn     = 1'b0;
      pll_locked = 1'b0;
      req_valid  = 1'b0;
      req_chan   = 2'd0;
      req_dir    = 1'b0;
      req_steps  = 8'd0;
      repeat (3) @(negedge clk);

      check("rst_sys_rst_n", 32'(sys_rst_n), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_phasestep", 32'(phasestep), 1);
      check("rst_phaseloadreg", 32'(phaseloadreg), 1);
      check("rst_phase_pos", 32'(phase_pos), 0);
      check("rst_relock_cnt", 32'(relock_cnt), 0);
      check("rst_done", 32'(done), 0);

      pll_locked = 1'b1;
      resetn     = 1'b1;
      measure_rise("lock_rise");

      send(2'd1, 1'b0, 8'd3, 1, 1'b0, 26, 3, 24'h00_03_00);
      wait_drain();
      send(2'd0, 1'b1, 8'd2, 1, 1'b0, 18, 2, 24'h00_03_FE);
      wait_drain();
      send(2'd0, 1'b0, 8'd2, 1, 1'b0, 18, 2, 24'h00_03_00);
      wait_drain();
      send(2'd3, 1'b0, 8'd4, 1, 1'b1, 0, 0, 24'h00_03_00);
      wait_drain();
      send(2'd2, 1'b0, 8'd0, 1, 1'b0, 0, 0, 24'h00_03_00);
      wait_drain();
      send(2'd2, 1'b1, 8'd1, 1, 1'b0, 10, 1, 24'hFF_03_00);
      wait_drain();
      send(2'd2, 1'b0, 8'd1, 1, 1'b0, 10, 1, 24'h00_03_00);
      wait_drain();
      check("loadreg_idle", 32'(phaseloadreg), 1);

      // Lock drop during the second pulse of a 5-step request.
      send(2'd1, 1'b0, 8'd5, 0, 1'b0, 0, 0, 24'h0);
      falls = 0;
      prev  = phasestep;
      n     = 0;
      while (falls < 2 && n < 100) begin
         @(negedge clk);
         if (prev && !phasestep) falls++;
         prev = phasestep;
         n++;
      end
      check("second_pulse_seen", falls, 2);
      check("pos_before_drop", 32'(phase_pos), 32'h00_04_00);
      pll_locked = 1'b0;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (!sys_rst_n) break;
      end
      check("unlock_to_rstn", n, 3);
      check("unlock_phasestep", 32'(phasestep), 1);
      check("unlock_phase_pos", 32'(phase_pos), 0);
      check("unlock_relock_cnt", 32'(relock_cnt), 1);
      check("unlock_ready", 32'(req_ready), 0);
      repeat (5) @(negedge clk);

      // Short lock glitch must not release the downstream reset.
      pll_locked = 1'b1;
      repeat (10) @(negedge clk);
      pll_locked = 1'b0;
      seen_high  = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen_high = seen_high | sys_rst_n;
      end
      check("glitch_rstn", 32'(seen_high), 0);
      check("glitch_relock_cnt", 32'(relock_cnt), 1);

      pll_locked = 1'b1;
      measure_rise("relock_rise");
      send(2'd2, 1'b1, 8'd1, 1, 1'b0, 10, 1, 24'hFF_00_00);
      wait_drain();

      // Asynchronous reset in the middle of a step.
      send(2'd1, 1'b1, 8'd4, 0, 1'b0, 0, 0, 24'h0);
      n = 0;
      while (phasestep && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("step_low_seen", 32'(phasestep), 0);
      #2 resetn = 1'b0;
      #1;
      check("arst_sys_rst_n", 32'(sys_rst_n), 0);
      check("arst_req_ready", 32'(req_ready), 0);
      check("arst_phasesel", 32'(phasesel), 0);
      check("arst_phasedir", 32'(phasedir), 0);
      check("arst_phasestep", 32'(phasestep), 1);
      check("arst_phaseloadreg", 32'(phaseloadreg), 1);
      check("arst_done", 32'(done), 0);
      check("arst_err", 32'(err), 0);
      check("arst_phase_pos", 32'(phase_pos), 0);
      check("arst_relock_cnt", 32'(relock_cnt), 0);
      @(negedge clk);
      resetn = 1'b1;
      measure_rise("post_reset_rise");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
